wbm_spi_ctrl: RTL and testbench
===============================

Name: wbm_spi_ctrl

Overview:
Wishbone-domain protocol sequencer for the SPI bridge. It takes bytes already crossed from the SPI RX path (one strobe per byte) and decodes them into command and data phases. It runs one classic-pipelined Wishbone B4 master cycle per command. For reads, it hands the response byte to the SPI TX path through a ready/strobe handshake.

Parameters:
ADDR_WIDTH, 7, width of wb_adr_o; must be 1..7, since the address field is cmd[6:0].
TIMEOUT, 255, maximum number of wb_clk_i cycles to wait for wb_ack_i after the request is accepted; must be 1..65535.

Ports:
wb_clk_i  in  1  Wishbone clock; the only clock.
wb_rst_i  in  1  reset, asynchronous, active-high.
rx_stb  in  1  one-cycle pulse: rx_data holds a new byte received from SPI.
rx_data  in  8  received byte, valid only while rx_stb=1.
tx_ready  in  1  SPI TX path can accept a byte.
tx_stb  out  1  one-cycle pulse: tx_data is handed to SPI TX.
tx_data  out  8  response byte.
wb_cyc_o  out  1  Wishbone cycle.
wb_stb_o  out  1  Wishbone strobe.
wb_we_o  out  1  Wishbone write enable.
wb_adr_o  out  ADDR_WIDTH  Wishbone address.
wb_dat_o  out  8  Wishbone write data.
wb_dat_i  in  8  Wishbone read data.
wb_ack_i  in  1  Wishbone acknowledge.
wb_stall_i  in  1  Wishbone pipelined stall.
overrun  out  1  one-cycle pulse: an rx byte was dropped because the block was busy.
timeout  out  1  one-cycle pulse: a Wishbone cycle was aborted with no ack.

Behaviour:
- Reset (asynchronous, wb_rst_i=1): state=IDLE; all outputs 0; the command register and timeout counter are cleared. Reset mid-cycle drops wb_cyc_o/wb_stb_o immediately and loses the pending response.
- Command byte format: bit7 = we; bits[ADDR_WIDTH-1:0] = address; bits[6:ADDR_WIDTH] are ignored. Byte 0x00 is filler and is ignored in IDLE, so it never starts a cycle.
- IDLE:
  - rx_stb with a non-zero byte latches the command.
  - we=1 → GET_DATA.
  - we=0 → WB_REQ on the next cycle.
- GET_DATA: the next rx_stb latches wb_dat_o → WB_REQ. A 0x00 byte here is valid data, not filler.
- WB_REQ:
  - wb_cyc_o=wb_stb_o=1 and wb_we_o, wb_adr_o, wb_dat_o are driven from the latched values.
  - On the first cycle with wb_stall_i=0, the request is accepted: wb_stb_o drops on the next cycle and the state moves to WB_WAIT.
  - If wb_ack_i arrives in the same cycle the request is accepted, it is honoured: go directly to the completion step.
- WB_WAIT:
  - wb_cyc_o=1, wb_stb_o=0.
  - On wb_ack_i: wb_cyc_o drops next cycle; reads capture wb_dat_i into tx_data and go to RESPOND; writes go to IDLE.
- Timeout:
  - The counter starts at 0 when WB_REQ is entered and increments each cycle in WB_REQ and WB_WAIT.
  - When it reaches TIMEOUT with no ack: pulse timeout, drop wb_cyc_o/wb_stb_o.
  - Reads go to RESPOND with tx_data=0xFF; writes go to IDLE.
  - An ack on the same cycle as expiry wins; no timeout pulse.
- RESPOND: tx_stb pulses for exactly one cycle on the first cycle with tx_ready=1, then → IDLE. With tx_ready held 0 the block waits indefinitely; there is no timeout here.
- Latency:
  - A read with a zero-wait slave (ack on the accept cycle) gives tx_stb 3 cycles after the command rx_stb.
  - A write gives wb_stb_o 1 cycle after the data rx_stb.
- Overrun: an rx_stb in WB_REQ, WB_WAIT or RESPOND pulses overrun the same cycle and the byte is discarded. No state change.
- Outputs are registered; wb_adr_o, wb_we_o and wb_dat_o hold their values between cycles.

Decomposition:
- Package wbm_spi_pkg holds:
  - state enum {IDLE, GET_DATA, WB_REQ, WB_WAIT, RESPOND};
  - CMD_WE_BIT=7;
  - FILLER_BYTE=8'h00;
  - TIMEOUT_BYTE=8'hFF.
- Sub-module: none; the timeout counter stays inline.

Test Plan:
- Read, zero-wait slave: rx 0x05, slave acks on the first stb with dat_i=0x3C → one wb cycle with adr=5, we=0; tx_stb with tx_data=0x3C 3 cycles after rx_stb.
- Write with stall: rx 0x8A then 0x00, wb_stall_i=1 for 4 cycles, ack 2 cycles later → wb_stb_o held 5 cycles, adr=0x0A, we=1, dat_o=0x00; no tx_stb; back in IDLE.
- Filler and overrun: rx 0x00 in IDLE → no cycle. Rx 0x01, then rx 0x55 while in WB_WAIT → overrun pulse, 0x55 not used; the response still arrives correctly.
- Timeout: TIMEOUT=8, read 0x02 with no ack → timeout pulse 8 cycles after WB_REQ entry, cyc drops, tx_data=0xFF. Repeat with ack on cycle 8 → no timeout, real data returned.
- TX backpressure: tx_ready=0 for 10 cycles after a read completes → tx_stb is a single pulse on the first tx_ready=1 cycle.
- Async reset: assert wb_rst_i mid-WB_WAIT, between clock edges → wb_cyc_o=0 immediately; after release, rx 0x03 runs a clean read.

Source files
------------

// File: rtl/wbm_spi_pkg.sv
// Shared types and constants for the Wishbone-side SPI bridge sequencer.
package wbm_spi_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_DATA = 3'd1,
        WB_REQ   = 3'd2,
        WB_WAIT  = 3'd3,
        RESPOND  = 3'd4
    } state_t;

    localparam int         CMD_WE_BIT   = 7;
    localparam logic [7:0] FILLER_BYTE  = 8'h00;
    localparam logic [7:0] TIMEOUT_BYTE = 8'hFF;

endpackage

// File: rtl/wbm_spi_ctrl.sv
// Turns SPI RX bytes into one pipelined Wishbone B4 master cycle per command
// and returns read data to the SPI TX path through a ready/strobe handshake.
module wbm_spi_ctrl
    import wbm_spi_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int TIMEOUT    = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  rx_stb,
    input  logic [7:0]            rx_data,
    input  logic                  tx_ready,
    output logic                  tx_stb,
    output logic [7:0]            tx_data,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [7:0]            wb_dat_o,
    input  logic [7:0]            wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_stall_i,
    output logic                  overrun,
    output logic                  timeout
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_cmd;
    logic [7:0]  r_dat;
    logic [15:0] r_tmo_cnt;
    logic        r_cyc;
    logic        r_stb;
    logic        r_tx_stb;
    logic [7:0]  r_tx_data;
    logic        r_timeout;

    logic w_in_bus;
    logic w_busy;
    logic w_accept;
    logic w_ack;
    logic w_expire;
    logic w_cmd_we;

    assign w_in_bus = (r_state == WB_REQ) || (r_state == WB_WAIT);
    assign w_busy   = w_in_bus || (r_state == RESPOND);
    assign w_cmd_we = r_cmd[CMD_WE_BIT];

    // An ack is only meaningful once the request is accepted; an ack on the
    // accept cycle itself completes the cycle without visiting WB_WAIT.
    assign w_accept = (r_state == WB_REQ) && !wb_stall_i;
    assign w_ack    = wb_ack_i && (w_accept || (r_state == WB_WAIT));
    assign w_expire = w_in_bus && (r_tmo_cnt == TMO_LAST) && !w_ack;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= IDLE;
            r_cmd     <= 8'h00;
            r_dat     <= 8'h00;
            r_tmo_cnt <= 16'd0;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_tx_stb  <= 1'b0;
            r_tx_data <= 8'h00;
            r_timeout <= 1'b0;
        end else begin
            r_tx_stb  <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (rx_stb && (rx_data != FILLER_BYTE)) begin
                        r_cmd <= rx_data;
                        if (rx_data[CMD_WE_BIT]) begin
                            r_state <= GET_DATA;
                        end else begin
                            r_state   <= WB_REQ;
                            r_cyc     <= 1'b1;
                            r_stb     <= 1'b1;
                            r_tmo_cnt <= 16'd0;
                        end
                    end
                end
                GET_DATA: begin
                    if (rx_stb) begin
                        r_dat     <= rx_data;
                        r_state   <= WB_REQ;
                        r_cyc     <= 1'b1;
                        r_stb     <= 1'b1;
                        r_tmo_cnt <= 16'd0;
                    end
                end
                WB_REQ, WB_WAIT: begin
                    r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    if (w_ack) begin
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        if (w_cmd_we) begin
                            r_state <= IDLE;
                        end else begin
                            r_tx_data <= wb_dat_i;
                            r_state   <= RESPOND;
                        end
                    end else if (w_expire) begin
                        r_cyc     <= 1'b0;
                        r_stb     <= 1'b0;
                        r_timeout <= 1'b1;
                        if (w_cmd_we) begin
                            r_state <= IDLE;
                        end else begin
                            r_tx_data <= TIMEOUT_BYTE;
                            r_state   <= RESPOND;
                        end
                    end else if (w_accept) begin
                        r_stb   <= 1'b0;
                        r_state <= WB_WAIT;
                    end
                end
                RESPOND: begin
                    if (tx_ready) begin
                        r_tx_stb <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_stb   = r_tx_stb;
    assign tx_data  = r_tx_data;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_stb;
    assign wb_we_o  = w_cmd_we;
    assign wb_adr_o = r_cmd[ADDR_WIDTH-1:0];
    assign wb_dat_o = r_dat;
    assign timeout  = r_timeout;
    // Flags the dropped byte in the very cycle its strobe is present.
    assign overrun  = rx_stb && w_busy;

endmodule

// File: tb/tb_wbm_spi_ctrl.sv
// Randomized scoreboard bench for wbm_spi_ctrl with a transaction-level
// model of expected Wishbone requests, responses, timeouts and overruns.
module tb_wbm_spi_ctrl;

    localparam int TMO   = 8;
    localparam int NEVER = 1000000;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       rx_stb   = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       tx_ready = 1'b1;
    logic       tx_stb;
    logic [7:0] tx_data;
    logic       wb_cyc_o;
    logic       wb_stb_o;
    logic       wb_we_o;
    logic [6:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i   = 8'h00;
    logic       wb_ack_i   = 1'b0;
    logic       wb_stall_i = 1'b0;
    logic       overrun;
    logic       timeout;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;

    int         slv_stall     = 0;
    int         slv_ack_delay = 0;
    logic [7:0] slv_data      = 8'h00;
    int         slv_stall_cnt = 0;
    int         slv_wait_cnt  = 0;

    logic [7:0]  last_dat = 8'h00;
    logic [15:0] exp_wb_q[$];
    int          exp_wb_cyc_q[$];
    logic [7:0]  exp_tx_q[$];
    int          exp_tx_cyc_q[$];
    int          exp_to_q[$];
    int          exp_ov_q[$];

    logic [15:0] m_wb;
    logic [7:0]  m_tx;
    int          m_c;

    wbm_spi_ctrl #(.ADDR_WIDTH(7), .TIMEOUT(TMO)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .rx_stb    (rx_stb),
        .rx_data   (rx_data),
        .tx_ready  (tx_ready),
        .tx_stb    (tx_stb),
        .tx_data   (tx_data),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_stall_i(wb_stall_i),
        .overrun   (overrun),
        .timeout   (timeout)
    );

    // Clock and cycle numbering: cycle N is the interval after the Nth rising edge.
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic tick(input logic stb, input logic [7:0] b, input logic txr);
        @(posedge clk);
        #1;
        rx_stb   = stb;
        rx_data  = b;
        tx_ready = txr;
    endtask

    // Slave model: stalls slv_stall cycles, then acks slv_ack_delay cycles after
    // acceptance (0 = on the accept cycle, negative = never).
    always @(posedge clk) begin
        #1;
        wb_ack_i   = 1'b0;
        wb_stall_i = 1'b0;
        wb_dat_i   = 8'($urandom);
        if (rst || !wb_cyc_o) begin
            slv_stall_cnt = 0;
            slv_wait_cnt  = 0;
        end else if (wb_stb_o) begin
            if (slv_stall_cnt < slv_stall) begin
                wb_stall_i = 1'b1;
                slv_stall_cnt++;
            end else if (slv_ack_delay == 0) begin
                wb_ack_i = 1'b1;
                wb_dat_i = slv_data;
            end else if (slv_ack_delay > 0) begin
                slv_wait_cnt = slv_ack_delay;
            end
        end else if (slv_wait_cnt > 0) begin
            slv_wait_cnt--;
            if (slv_wait_cnt == 0) begin
                wb_ack_i = 1'b1;
                wb_dat_i = slv_data;
            end
        end
    end

    // Monitor: every DUT event pops and checks the oldest matching expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_cyc_o && wb_stb_o && !wb_stall_i) begin
                if (exp_wb_q.size() == 0) begin
                    chk("wb_unexpected", 32'(wb_stb_o), 32'd0);
                end else begin
                    m_wb = exp_wb_q.pop_front();
                    m_c  = exp_wb_cyc_q.pop_front();
                    chk("wb_req_we_adr_dat", 32'({wb_we_o, wb_adr_o, wb_dat_o}), 32'(m_wb));
                    chk("wb_req_cycle", 32'(cyc_n), 32'(m_c));
                end
            end
            if (tx_stb) begin
                if (exp_tx_q.size() == 0) begin
                    chk("tx_unexpected", 32'(tx_stb), 32'd0);
                end else begin
                    m_tx = exp_tx_q.pop_front();
                    m_c  = exp_tx_cyc_q.pop_front();
                    chk("tx_data", 32'(tx_data), 32'(m_tx));
                    chk("tx_cycle", 32'(cyc_n), 32'(m_c));
                end
            end
            if (timeout) begin
                if (exp_to_q.size() == 0) begin
                    chk("timeout_unexpected", 32'(timeout), 32'd0);
                end else begin
                    m_c = exp_to_q.pop_front();
                    chk("timeout_cycle", 32'(cyc_n), 32'(m_c));
                    chk("timeout_cyc_dropped", 32'(wb_cyc_o), 32'd0);
                end
            end
            if (overrun) begin
                if (exp_ov_q.size() == 0) begin
                    chk("overrun_unexpected", 32'(overrun), 32'd0);
                end else begin
                    m_c = exp_ov_q.pop_front();
                    chk("overrun_cycle", 32'(cyc_n), 32'(m_c));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_stb"},   32'(tx_stb),   32'd0);
        chk({tag, "_tx_data"},  32'(tx_data),  32'd0);
        chk({tag, "_cyc"},      32'(wb_cyc_o), 32'd0);
        chk({tag, "_stb"},      32'(wb_stb_o), 32'd0);
        chk({tag, "_we"},       32'(wb_we_o),  32'd0);
        chk({tag, "_adr"},      32'(wb_adr_o), 32'd0);
        chk({tag, "_dat_o"},    32'(wb_dat_o), 32'd0);
        chk({tag, "_overrun"},  32'(overrun),  32'd0);
        chk({tag, "_timeout"},  32'(timeout),  32'd0);
    endtask

    // One command: s = stall cycles, d = ack delay after accept (<0 never),
    // hold = extra tx_ready-low cycles in RESPOND, gap = idle cycles before a
    // write's data byte, junk = offset from request entry of a stray rx byte
    // (-1 none, -2 random inside the busy window).
    task automatic do_txn(input logic [7:0] cmd, input logic [7:0] dat, input logic [7:0] rdat,
                          input int s, input int d, input int hold, input int gap, input int junk);
        logic we;
        bit   to;
        int   e, ack_idx, win, comp, rel, busy_end, end_c, jc, nxt;
        we            = cmd[7];
        slv_stall     = s;
        slv_ack_delay = d;
        slv_data      = rdat;
        tick(1'b1, cmd, 1'b1);
        if (we) begin
            repeat (gap) tick(1'b0, 8'($urandom), 1'b1);
            tick(1'b1, dat, 1'b1);
        end
        e = cyc_n + 1;
        exp_wb_q.push_back({we, cmd[6:0], we ? dat : last_dat});
        exp_wb_cyc_q.push_back(e + s);
        if (we) last_dat = dat;
        ack_idx = (d < 0) ? NEVER : s + 1 + d;
        to      = ack_idx > TMO;
        win     = to ? TMO : ack_idx;
        comp    = e + win - 1;
        if (to) exp_to_q.push_back(comp + 1);
        if (!we) begin
            rel = comp + 1 + hold;
            exp_tx_q.push_back(to ? 8'hFF : rdat);
            exp_tx_cyc_q.push_back(rel + 1);
            busy_end = rel;
            end_c    = rel + 2;
        end else begin
            rel      = 0;
            busy_end = comp;
            end_c    = comp + 2;
        end
        if (junk == -2) jc = int'($urandom_range(busy_end, e));
        else if (junk >= 0) jc = e + junk;
        else jc = -1;
        if (jc >= 0) exp_ov_q.push_back(jc);
        while (cyc_n < end_c) begin
            nxt = cyc_n + 1;
            tick(nxt == jc, 8'($urandom), we ? 1'b1 : (nxt >= rel));
        end
        chk("idle_after_txn", 32'(wb_cyc_o), 32'd0);
    endtask

    initial begin
        logic [7:0] cmd;
        int d;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Zero-wait read: response three cycles after the command byte.
        do_txn(8'h05, 8'h00, 8'h3C, 0, 0, 0, 0, -1);
        // Write of a 0x00 data byte through a stalling slave.
        do_txn(8'h8A, 8'h00, 8'h00, 4, 2, 0, 1, -1);
        // Filler in IDLE starts nothing.
        tick(1'b1, 8'h00, 1'b1);
        repeat (4) tick(1'b0, 8'h00, 1'b1);
        chk("filler_no_cycle", 32'(wb_cyc_o), 32'd0);
        // Stray byte during WB_WAIT is dropped with an overrun pulse.
        do_txn(8'h01, 8'h00, 8'hA7, 0, 3, 0, 0, 2);
        // No ack at all, then an ack exactly on the expiry cycle.
        do_txn(8'h02, 8'h00, 8'h11, 0, -1, 0, 0, -1);
        do_txn(8'h02, 8'h00, 8'h6B, 0, TMO - 1, 0, 0, -1);
        // TX backpressure for ten cycles.
        do_txn(8'h07, 8'h00, 8'hC3, 0, 0, 10, 0, -1);

        // Asynchronous reset in the middle of WB_WAIT.
        slv_stall     = 0;
        slv_ack_delay = -1;
        tick(1'b1, 8'h04, 1'b1);
        exp_wb_q.push_back({1'b0, 7'h04, last_dat});
        exp_wb_cyc_q.push_back(cyc_n + 1);
        repeat (3) tick(1'b0, 8'h00, 1'b1);
        chk("pre_reset_cyc", 32'(wb_cyc_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_cyc", 32'(wb_cyc_o), 32'd0);
        chk("async_reset_stb", 32'(wb_stb_o), 32'd0);
        exp_tx_q.delete();
        exp_tx_cyc_q.delete();
        exp_to_q.delete();
        exp_ov_q.delete();
        last_dat = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset2");
        rst = 1'b0;
        do_txn(8'h03, 8'h00, 8'h5E, 0, 1, 0, 0, -1);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                tick(1'b1, 8'h00, 1'b1);
                tick(1'b0, 8'h00, 1'b1);
            end
            cmd = 8'($urandom_range(1, 255));
            d   = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 9));
            do_txn(cmd, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), d,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                   ($urandom_range(0, 2) == 0) ? -2 : -1);
        end

        repeat (3) tick(1'b0, 8'h00, 1'b1);
        chk("left_wb",      32'(exp_wb_q.size()), 32'd0);
        chk("left_tx",      32'(exp_tx_q.size()), 32'd0);
        chk("left_timeout", 32'(exp_to_q.size()), 32'd0);
        chk("left_overrun", 32'(exp_ov_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
